// File: rtl/snn_pkg.sv
// Shared types and helpers for the input-neuron layer: FSM states,
// saturating increment and the channel-to-bit mapping of the packed counts.
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } nu_state_t;

   // Increment that sticks at maxv instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
      return (v >= maxv) ? maxv : v + 32'd1;
   endfunction

   // Lowest bit of channel ch inside a packed count vector of cw-bit fields.
   function automatic int count_lsb(input int ch, input int cw);
      return ch * cw;
   endfunction

   function automatic logic [31:0] count_field(input logic [1023:0] packed_cnt,
                                              input int ch, input int cw);
      logic [31:0] r;
      r = '0;
      for (int b = 0; b < cw; b++)
         r[b] = packed_cnt[count_lsb(ch, cw) + b];
      return r;
   endfunction

endpackage

// File: rtl/ip_nu_cell.sv
// One input channel: registered spike forward plus a saturating spike counter.
module ip_nu_cell
   import snn_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          step,
   input  logic          en,
   input  logic          spike,
   output logic          spike_out,
   output logic [CW-1:0] cnt
);

   localparam logic [31:0] CNT_MAX = 32'({CW{1'b1}});

   logic hit;
   assign hit = step & en & spike;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spike_out <= 1'b0;
         cnt       <= '0;
      end else begin
         // Forwarded spike lives for exactly the cycle after an accepted step.
         spike_out <= hit;
         if (clr)
            cnt <= '0;
         else if (hit)
            cnt <= CW'(sat_inc(32'(cnt), CNT_MAX));
      end
   end

endmodule

// File: rtl/ip_nu_array.sv
// Input-neuron layer: per-channel spike counters over a T-step window with a
// valid/ready handoff of the frozen counts. IP_NU_MASK_EN adds ch_mask.
module ip_nu_array
   import snn_pkg::*;
#(
   parameter int N  = 784,
   parameter int CW = 8,
   parameter int T  = 24,
   parameter int TW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    spike_in,
   input  logic            start_img,
   input  logic            start_step,
`ifdef IP_NU_MASK_EN
   input  logic [N-1:0]    ch_mask,
`endif
   output logic [N-1:0]    spike_out,
   output logic [N*CW-1:0] count,
   output logic [TW-1:0]   step_idx,
   output logic            busy,
   output logic            valid,
   input  logic            ready
);

   localparam logic [TW-1:0] LAST_IDX = TW'(T - 1);

   nu_state_t state;
   logic      clr, step;
   logic [N-1:0] en;
   logic [N-1:0][CW-1:0] cnt_w;

`ifdef IP_NU_MASK_EN
   assign en = ch_mask;
`else
   assign en = '1;
`endif

   // start_img wins over a coincident start_step; in DONE it only takes
   // effect together with ready so unaccepted counts are never lost.
   always_comb begin
      clr = 1'b0;
      unique case (state)
         IDLE:    clr = start_img;
         RUN:     clr = start_img;
         DONE:    clr = start_img & ready;
         default: clr = 1'b0;
      endcase
   end

   assign step = (state == RUN) & start_step & ~start_img;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         step_idx <= '0;
         busy     <= 1'b0;
         valid    <= 1'b0;
      end else begin
         if (clr)
            step_idx <= '0;
         else if (step)
            step_idx <= step_idx + 1'b1;

         unique case (state)
            IDLE: begin
               if (start_img) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (step && step_idx == LAST_IDX) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  valid <= 1'b1;
               end
            end
            DONE: begin
               if (ready) begin
                  valid <= 1'b0;
                  if (start_img) begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               valid <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_cell
      ip_nu_cell #(.CW(CW)) u_cell (
         .clk       (clk),
         .rst       (rst),
         .clr       (clr),
         .step      (step),
         .en        (en[i]),
         .spike     (spike_in[i]),
         .spike_out (spike_out[i]),
         .cnt       (cnt_w[i])
      );
      assign count[count_lsb(i, CW) +: CW] = cnt_w[i];
   end

endmodule

// File: tb/tb_ip_nu_array.sv
// Directed bench for ip_nu_array: a T=3 instance for window/handshake/abort/reset
// checks and a T=20 instance for counter saturation.
module tb_ip_nu_array;

   localparam int N = 4;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // DUT a: T=3
   logic [N-1:0]    a_spike_in = '0;
   logic            a_start_img = 1'b0, a_start_step = 1'b0, a_ready = 1'b0;
   logic [N-1:0]    a_spike_out;
   logic [N*CW-1:0] a_count;
   logic [1:0]      a_step_idx;
   logic            a_busy, a_valid;
`ifdef IP_NU_MASK_EN
   logic [N-1:0]    a_mask = '1;
`endif

   // DUT b: T=20
   logic [N-1:0]    b_spike_in = '0;
   logic            b_start_img = 1'b0, b_start_step = 1'b0, b_ready = 1'b0;
   logic [N-1:0]    b_spike_out;
   logic [N*CW-1:0] b_count;
   logic [4:0]      b_step_idx;
   logic            b_busy, b_valid;
`ifdef IP_NU_MASK_EN
   logic [N-1:0]    b_mask = '1;
`endif

   ip_nu_array #(.N(N), .CW(CW), .T(3), .TW(2)) dut_a (
      .clk(clk), .rst(rst), .spike_in(a_spike_in), .start_img(a_start_img),
      .start_step(a_start_step),
`ifdef IP_NU_MASK_EN
      .ch_mask(a_mask),
`endif
      .spike_out(a_spike_out), .count(a_count), .step_idx(a_step_idx),
      .busy(a_busy), .valid(a_valid), .ready(a_ready)
   );

   ip_nu_array #(.N(N), .CW(CW), .T(20), .TW(5)) dut_b (
      .clk(clk), .rst(rst), .spike_in(b_spike_in), .start_img(b_start_img),
      .start_step(b_start_step),
`ifdef IP_NU_MASK_EN
      .ch_mask(b_mask),
`endif
      .spike_out(b_spike_out), .count(b_count), .step_idx(b_step_idx),
      .busy(b_busy), .valid(b_valid), .ready(b_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks every output of DUT a against expected values.
   task automatic chk_a(input string tag, input logic [15:0] cnt, input logic [1:0] idx,
                        input logic bsy, input logic vld, input logic [3:0] so);
      check({tag, ".count"},     32'(a_count),     32'(cnt));
      check({tag, ".step_idx"},  32'(a_step_idx),  32'(idx));
      check({tag, ".busy"},      32'(a_busy),      32'(bsy));
      check({tag, ".valid"},     32'(a_valid),     32'(vld));
      check({tag, ".spike_out"}, 32'(a_spike_out), 32'(so));
   endtask

   task automatic step_a(input logic [3:0] s);
      a_spike_in = s; a_start_step = 1'b1;
      tick();
      a_start_step = 1'b0; a_spike_in = '0;
   endtask

   initial begin
      #12;
      chk_a("reset", 16'h0000, 2'd0, 1'b0, 1'b0, 4'h0);
      check("reset.b_count", 32'(b_count), 32'h0);
      rst = 1'b1;
      tick();

      // 1. basic window
      a_start_img = 1'b1; tick(); a_start_img = 1'b0;
      chk_a("t1.start", 16'h0000, 2'd0, 1'b1, 1'b0, 4'h0);
      step_a(4'b1111);
      chk_a("t1.s1", 16'h1111, 2'd1, 1'b1, 1'b0, 4'b1111);
      step_a(4'b0101);
      chk_a("t1.s2", 16'h1212, 2'd2, 1'b1, 1'b0, 4'b0101);
      step_a(4'b0001);
      chk_a("t1.s3", 16'h1213, 2'd3, 1'b0, 1'b1, 4'b0001);

      // 3. backpressure in DONE
      a_ready = 1'b0; a_start_step = 1'b1; a_start_img = 1'b1; a_spike_in = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_a("t3.hold", 16'h1213, 2'd3, 1'b0, 1'b1, 4'h0);
      end
      a_start_step = 1'b0; a_start_img = 1'b0; a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      chk_a("t3.accept", 16'h1213, 2'd3, 1'b0, 1'b0, 4'h0);
      a_start_step = 1'b1; tick(); a_start_step = 1'b0; a_spike_in = '0;
      chk_a("t3.idle_step", 16'h1213, 2'd3, 1'b0, 1'b0, 4'h0);

      // 4. abort mid-window, then DONE start_img+ready restart
      a_start_img = 1'b1; tick(); a_start_img = 1'b0;
      chk_a("t4.start", 16'h0000, 2'd0, 1'b1, 1'b0, 4'h0);
      step_a(4'b1111);
      step_a(4'b1111);
      chk_a("t4.two", 16'h2222, 2'd2, 1'b1, 1'b0, 4'b1111);
      a_start_img = 1'b1; a_start_step = 1'b1; a_spike_in = 4'b1111;
      tick();
      a_start_img = 1'b0; a_start_step = 1'b0; a_spike_in = '0;
      chk_a("t4.abort", 16'h0000, 2'd0, 1'b1, 1'b0, 4'h0);
      step_a(4'b1111);
      step_a(4'b1111);
      step_a(4'b1111);
      chk_a("t4.done", 16'h3333, 2'd3, 1'b0, 1'b1, 4'b1111);
      a_start_img = 1'b1; a_ready = 1'b1; tick(); a_start_img = 1'b0; a_ready = 1'b0;
      chk_a("t4.restart", 16'h0000, 2'd0, 1'b1, 1'b0, 4'h0);

      // 5. async reset mid-RUN
      step_a(4'b1111);
      chk_a("t5.pre", 16'h1111, 2'd1, 1'b1, 1'b0, 4'b1111);
      #2 rst = 1'b0;
      #1 chk_a("t5.async", 16'h0000, 2'd0, 1'b0, 1'b0, 4'h0);
      @(negedge clk); rst = 1'b1;
      tick();
      step_a(4'b1111);
      chk_a("t5.ignored", 16'h0000, 2'd0, 1'b0, 1'b0, 4'h0);

      // 2. saturation on DUT b
      b_start_img = 1'b1; tick(); b_start_img = 1'b0;
      for (int i = 0; i < 20; i++) begin
         b_spike_in = 4'b0001; b_start_step = 1'b1;
         tick();
         if (i == 14) check("t2.at15", 32'(b_count), 32'h000F);
         if (i == 15) check("t2.at16", 32'(b_count), 32'h000F);
      end
      b_start_step = 1'b0; b_spike_in = '0;
      check("t2.count", 32'(b_count), 32'h000F);
      check("t2.valid", 32'(b_valid), 32'h1);
      check("t2.step_idx", 32'(b_step_idx), 32'd20);
      check("t2.spike_out", 32'(b_spike_out), 32'h1);
      tick();
      check("t2.spike_clr", 32'(b_spike_out), 32'h0);

`ifdef IP_NU_MASK_EN
      // 6. channel mask
      a_start_img = 1'b1; tick(); a_start_img = 1'b0;
      a_mask = 4'b1010;
      step_a(4'b1111);
      chk_a("t6.s1", 16'h1010, 2'd1, 1'b1, 1'b0, 4'b1010);
      step_a(4'b1111);
      chk_a("t6.s2", 16'h2020, 2'd2, 1'b1, 1'b0, 4'b1010);
      step_a(4'b1111);
      chk_a("t6.s3", 16'h3030, 2'd3, 1'b0, 1'b1, 4'b1010);
      a_mask = '1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
